// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer for the shared LC-3
// memory port. Requester 0 is the CPU, requester 1 is the I/O/DMA engine.
// Flow: IDLE (arbitrate, latch winner) -> ACCESS (hold until mem_ready_i)
// -> RESP (one-cycle ack) -> IDLE.
// Optional build macro MEM_ARB_TIMEOUT_EN: aborts an ACCESS that lasts
// TIMEOUT cycles and reports it with err_o alongside the ack.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              grant_id_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              pick;

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Access-duration counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // TIMEOUT only matters when the abort feature is built in.
    wire unused_timeout = (TIMEOUT == 0);
`endif

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/abort in ACCESS.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        busy_d       = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        // Contested: serve whoever did not win last; otherwise the lone requester.
        pick = (req0_i && req1_i) ? ~last_grant_q : req1_i;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req0_i || req1_i) begin
                    grant_id_d   = pick;
                    last_grant_d = pick;
                    mem_addr_d   = pick ? addr1_i  : addr0_i;
                    mem_wdata_d  = pick ? wdata1_i : wdata0_i;
                    mem_we_d     = pick ? we1_i    : we0_i;
                    mem_en_d     = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ST_ACCESS: begin
                // Requester inputs are deliberately ignored here.
                if (mem_ready_i) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        if (grant_id_q) rdata1_d = mem_rdata_i;
                        else            rdata0_d = mem_rdata_i;
                    end
                    ack0_d  = ~grant_id_q;
                    ack1_d  = grant_id_q;
                    state_d = ST_RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // TIMEOUT-th ACCESS cycle without ready: abort, keep rdata.
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack0_d   = ~grant_id_q;
                    ack1_d   = grant_id_q;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grant_id_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed-vector bench for mem_port_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err, busy, grant_id, mem_en, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .err_o(err), .busy_o(busy), .grant_id_o(grant_id),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0; mem_ready = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ack0, ack1, err, busy, grant_id, mem_en, mem_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b exp=0000000", {ack0, ack1, err, busy, grant_id, mem_en, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, rdata0, rdata1});
        end
        $display("test_reset done");
    endtask

    task automatic test_read_req0();
        int ack1_seen = 0;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 16'h3000;
        tick();
        req0 = 0;
        n_checks++;
        if ({mem_en, busy, grant_id, mem_we, mem_addr} !== {4'b1100, 16'h3000}) begin
            n_fail++;
            $display("FAIL read_grant got en=%b busy=%b gid=%b we=%b addr=%h exp 1 1 0 0 3000",
                     mem_en, busy, grant_id, mem_we, mem_addr);
        end
        tick();
        if (ack1) ack1_seen++;
        tick();
        if (ack1) ack1_seen++;
        n_checks++;
        if (mem_en !== 1'b1 || ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait got en=%b ack0=%b exp en=1 ack0=0", mem_en, ack0);
        end
        mem_ready = 1; mem_rdata = 16'h1234;
        tick();
        mem_ready = 0; mem_rdata = 16'h5555;
        if (ack1) ack1_seen++;
        n_checks++;
        if ({ack0, mem_en, busy, rdata0, rdata1} !== {3'b101, 16'h1234, 16'h0000}) begin
            n_fail++;
            $display("FAIL read_ack got ack0=%b en=%b busy=%b rdata0=%h rdata1=%h exp 1 0 1 1234 0000",
                     ack0, mem_en, busy, rdata0, rdata1);
        end
        tick();
        if (ack1) ack1_seen++;
        n_checks++;
        if (ack0 !== 1'b0 || busy !== 1'b0 || rdata0 !== 16'h1234) begin
            n_fail++;
            $display("FAIL read_after got ack0=%b busy=%b rdata0=%h exp 0 0 1234", ack0, busy, rdata0);
        end
        n_checks++;
        if (ack1_seen != 0) begin
            n_fail++;
            $display("FAIL read_no_ack1 got=%0d exp=0", ack1_seen);
        end
        $display("test_read_req0 done rdata0=%h", rdata0);
    endtask

    task automatic test_contested();
        logic exp_g;
        do_reset();
        req0 = 1; req1 = 1; mem_ready = 1;
        exp_g = 1'b0;
        for (int t = 0; t < 4; t++) begin
            mem_rdata = DW'(16'hA000 + t);
            tick();
            n_checks++;
            if (busy !== 1'b1 || grant_id !== exp_g) begin
                n_fail++;
                $display("FAIL contested_grant%0d got busy=%b gid=%b exp busy=1 gid=%b", t, busy, grant_id, exp_g);
            end
            tick();
            n_checks++;
            if ({ack0, ack1} !== (exp_g ? 2'b01 : 2'b10) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL contested_ack%0d got ack0=%b ack1=%b busy=%b exp gid=%b busy=1",
                         t, ack0, ack1, busy, exp_g);
            end
            tick();
            n_checks++;
            if ({ack0, ack1, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL contested_bubble%0d got ack0=%b ack1=%b busy=%b exp 000", t, ack0, ack1, busy);
            end
            $display("contested txn %0d gid=%b", t, exp_g);
            exp_g = ~exp_g;
        end
        n_checks++;
        if (rdata0 !== 16'hA002 || rdata1 !== 16'hA003) begin
            n_fail++;
            $display("FAIL contested_rdata got %h %h exp a002 a003", rdata0, rdata1);
        end
        req0 = 0; req1 = 0; mem_ready = 0;
    endtask

    task automatic test_write_req1();
        do_reset();
        req1 = 1; we1 = 1; addr1 = 16'hFE06; wdata1 = 16'h0041;
        mem_rdata = 16'hDEAD;
        tick();
        req1 = 0; we1 = 0; addr1 = 16'h1111; wdata1 = 16'h2222;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({mem_en, mem_we, grant_id, mem_addr, mem_wdata} !== {3'b111, 16'hFE06, 16'h0041}) begin
                n_fail++;
                $display("FAIL write_hold%0d got en=%b we=%b gid=%b addr=%h wd=%h exp 1 1 1 fe06 0041",
                         c, mem_en, mem_we, grant_id, mem_addr, mem_wdata);
            end
            tick();
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        n_checks++;
        if ({ack1, ack0, mem_en, mem_we, rdata1} !== {4'b1000, 16'h0000}) begin
            n_fail++;
            $display("FAIL write_ack got ack1=%b ack0=%b en=%b we=%b rdata1=%h exp 1 0 0 0 0000",
                     ack1, ack0, mem_en, mem_we, rdata1);
        end
        tick();
        $display("test_write_req1 done");
    endtask

    task automatic test_withdraw();
        do_reset();
        req0 = 1; addr0 = 16'h0042;
        tick();
        tick();
        req0 = 0;
        tick();
        mem_ready = 1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 0;
        n_checks++;
        if (ack0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL withdraw_ack got ack0=%b rdata0=%h exp 1 beef", ack0, rdata0);
        end
        tick();
        $display("test_withdraw done");
    endtask

    task automatic test_reset_mid_access();
        int acks = 0;
        do_reset();
        req0 = 1; addr0 = 16'h0100;
        tick();
        req0 = 0;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset got en=%b busy=%b addr=%h exp 0 0 0000", mem_en, busy, mem_addr);
        end
        mem_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack0 || ack1) acks++;
        end
        mem_ready = 0;
        #3 rst_n = 1;
        tick();
        if (ack0 || ack1) acks++;
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_no_ack got=%0d exp=0", acks);
        end
        req0 = 1; req1 = 1;
        tick();
        req0 = 0; req1 = 0;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant got busy=%b gid=%b exp 1 0", busy, grant_id);
        end
        do_reset();
        $display("test_reset_mid_access done");
    endtask

    task automatic test_timeout();
        do_reset();
        req0 = 1; addr0 = 16'h0200;
        mem_rdata = 16'h7777;
        tick();
        req0 = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (mem_en !== 1'b1 || ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait%0d got en=%b ack0=%b exp 1 0", c, mem_en, ack0);
            end
        end
        tick();
        n_checks++;
        if ({mem_en, ack0, err, busy, rdata0} !== {4'b0111, 16'h0000}) begin
            n_fail++;
            $display("FAIL timeout_abort got en=%b ack0=%b err=%b busy=%b rdata0=%h exp 0 1 1 1 0000",
                     mem_en, ack0, err, busy, rdata0);
        end
        tick();
        n_checks++;
        if ({ack0, err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_after got ack0=%b err=%b busy=%b exp 000", ack0, err, busy);
        end
`else
        begin
            int drops = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (mem_en !== 1'b1 || ack0 !== 1'b0 || err !== 1'b0) drops++;
            end
            n_checks++;
            if (drops != 0) begin
                n_fail++;
                $display("FAIL no_timeout got=%0d bad cycles exp=0", drops);
            end
            mem_ready = 1; mem_rdata = 16'h0BAD;
            tick();
            mem_ready = 0;
            n_checks++;
            if (ack0 !== 1'b1 || err !== 1'b0 || rdata0 !== 16'h0BAD) begin
                n_fail++;
                $display("FAIL late_complete got ack0=%b err=%b rdata0=%h exp 1 0 0bad", ack0, err, rdata0);
            end
            tick();
        end
`endif
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_read_req0();
        test_contested();
        test_write_req1();
        test_withdraw();
        test_reset_mid_access();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
